// File: rtl/gfx_raster_frag_serializer_pkg.sv
// Shared types for the fine-raster fragment serializer.
// Tile geometry, fragment coordinates and ping-pong slot layout.
package gfx_raster_frag_serializer_pkg;

  localparam int unsigned SIZE     = 4;
  localparam int unsigned BITS     = 2;
  localparam int unsigned CELLS    = SIZE * SIZE;
  localparam int unsigned IDX_W    = 2 * BITS;
  localparam int unsigned COORD_W  = 8;
  localparam int unsigned COARSE_W = COORD_W - BITS;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } frag_xy;

  typedef logic [CELLS-1:0] raster_mask;
  typedef frag_xy [CELLS-1:0] raster_frags;

  typedef struct packed {
    raster_mask          mask;
    logic [COARSE_W-1:0] coarse_x;
    logic [COARSE_W-1:0] coarse_y;
    logic                full;
  } raster_tile_slot;

  // Fine bits are the raw cell index split into x (low) and y (high) halves.
  function automatic frag_xy frag_from_index(input logic [COARSE_W-1:0] coarse_x,
                                             input logic [COARSE_W-1:0] coarse_y,
                                             input logic [IDX_W-1:0]    idx);
    frag_xy f;
    f.x = {coarse_x, idx[BITS-1:0]};
    f.y = {coarse_y, idx[IDX_W-1:BITS]};
    return f;
  endfunction

endpackage

// File: rtl/gfx_raster_frag_serializer_if.sv
// Tile input and fragment output streams of the serializer.
// master = raster array / consumer side, slave = serializer.
interface gfx_raster_frag_serializer_if;
  import gfx_raster_frag_serializer_pkg::*;

  logic        in_valid;
  raster_frags in_frags;
  raster_mask  in_paint;
  logic        stall;
  logic        out_valid;
  logic        out_ready;
  frag_xy      out_frag;

  modport master (
    output in_valid, in_frags, in_paint, out_ready,
    input  stall, out_valid, out_frag
  );

  modport slave (
    input  in_valid, in_frags, in_paint, out_ready,
    output stall, out_valid, out_frag
  );

endinterface

// File: rtl/gfx_raster_frag_serializer_lsb_pick.sv
// Lowest-set-bit picker over a tile paint mask.
// Returns the bit index, a non-empty flag and the mask with that bit cleared.
module gfx_raster_frag_serializer_lsb_pick
  import gfx_raster_frag_serializer_pkg::*;
(
  input  raster_mask       mask_i,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o,
  output raster_mask       mask_next_o
);

  always_comb begin
    index_o = '0;
    // Scan high to low so the last hit is the lowest set bit.
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (mask_i[i]) index_o = IDX_W'(i);
    end
  end

  assign any_o       = |mask_i;
  assign mask_next_o = mask_i & (mask_i - raster_mask'(1));

endmodule

// File: rtl/gfx_raster_frag_serializer.sv
// Two-slot ping-pong tile buffer emitting painted fragments one per cycle,
// lowest cell index first, with a registered stall back to the raster array.
module gfx_raster_frag_serializer
  import gfx_raster_frag_serializer_pkg::*;
(
  input logic                          clk,
  input logic                          rst_n,
  gfx_raster_frag_serializer_if.slave  bus
);

  raster_tile_slot  slots_q [2];
  raster_tile_slot  slots_d [2];
  logic             head_q, head_d;

  raster_tile_slot  head_slot;
  logic [IDX_W-1:0] head_idx;
  logic             head_any;
  raster_mask       head_mask_next;

  logic stall;
  logic tail;
  logic accept;
  logic pop;

  assign head_slot = slots_q[head_q];

  gfx_raster_frag_serializer_lsb_pick u_lsb_pick (
    .mask_i      (head_slot.mask),
    .index_o     (head_idx),
    .any_o       (head_any),
    .mask_next_o (head_mask_next)
  );

  // Stall depends on registered fill state only, so it lags a drain by one cycle.
  assign stall  = slots_q[0].full & slots_q[1].full;
  assign tail   = head_q ^ (slots_q[0].full ^ slots_q[1].full);
  assign accept = bus.in_valid & ~stall;
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    slots_d = slots_q;
    head_d  = head_q;
    if (pop) begin
      slots_d[head_q].mask = head_mask_next;
      if (head_mask_next == '0) begin
        slots_d[head_q].full = 1'b0;
        head_d               = ~head_q;
      end
    end
    // Tail never equals a full head here, so an accept never clobbers a pop.
    if (accept && (bus.in_paint != '0)) begin
      slots_d[tail].mask     = bus.in_paint;
      slots_d[tail].coarse_x = bus.in_frags[0].x[COORD_W-1:BITS];
      slots_d[tail].coarse_y = bus.in_frags[0].y[COORD_W-1:BITS];
      slots_d[tail].full     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q[0] <= '0;
      slots_q[1] <= '0;
      head_q     <= 1'b0;
    end else begin
      slots_q <= slots_d;
      head_q  <= head_d;
    end
  end

  always_comb begin
    bus.stall     = stall;
    bus.out_valid = head_slot.full & head_any;
    bus.out_frag  = frag_from_index(head_slot.coarse_x, head_slot.coarse_y, head_idx);
  end

  // Only the coarse bits of cell 0 are stored.
  logic unused_frags;
  assign unused_frags = ^{bus.in_frags[CELLS-1:1],
                          bus.in_frags[0].x[BITS-1:0], bus.in_frags[0].y[BITS-1:0]};

endmodule
